top_level: RTL and testbench
============================

# top_level

Self-contained Hamming SECDED encoder that runs as program 1 of the CSE141L flow. On reset release it reads 15 packed 11-bit messages from data memory and computes four Hamming parity bits plus an overall parity bit for each. It writes the resulting 16-bit codewords back to memory, then raises `done`. It is the top of the design; the bench preloads and inspects memory hierarchically through instance `dm1`, array `core`.

## Interface
- `NUM_MSG`, 15: messages processed.
- `OUT_BASE`, 30: byte address of the first output codeword.
- `MEM_DEPTH`, 256: data-memory bytes.
- `clk`  input  1  sole clock; all state updates on its rising edge.
- `reset`  input  1  asynchronous, active-low.
- `done`  output  1  high when all codewords are written; registered.

## Operation
- Memory: instance `dm1`, byte array `core[0:MEM_DEPTH-1]`.
  - One port; combinational read, synchronous write.
  - Not cleared by reset; the bench preloads it.
- Input message i, for i = 0..14, is `d[11:1] = {core[2i+1][2:0], core[2i]}`. Bits `core[2i+1][7:3]` are ignored.
- Parity, computed combinationally:
  - p8 = ^d[11:5]
  - p4 = ^d[11:8] ^ ^d[4:2]
  - p2 = d11^d10^d7^d6^d4^d3^d1
  - p1 = d11^d9^d7^d5^d4^d2^d1
  - p0 = ^d ^ p8 ^ p4 ^ p2 ^ p1
- Codeword = {d[11:5], p8, d[4:2], p4, d1, p2, p1, p0}.
  - Low byte goes to `core[OUT_BASE+2i]`.
  - High byte goes to `core[OUT_BASE+2i+1]`.
- FSM states: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, FIN.
  - IDLE → RD_LO on the first clock after reset release.
  - RD_LO: latch low byte.
  - RD_HI: latch high byte.
  - WR_LO: write low codeword byte.
  - WR_HI: write high codeword byte, then increment i.
  - WR_HI → RD_LO if i < NUM_MSG-1, else → FIN.
  - FIN: `done`=1, no further memory writes. Held until reset.
- 4-bit message counter i; must never exceed NUM_MSG-1. No writes occur outside bytes 30..59.

## Timing
- While `reset`=0: state=IDLE, i=0, `done`=0. Memory is untouched.
- Reset assertion mid-run aborts immediately. Partially written outputs remain. The run restarts from message 0 on release.
- After release:
  - 1 cycle in IDLE, then 4 cycles per message.
  - The final write lands on the rising edge ending cycle 61.
  - `done` goes high on that same edge, total latency 61 cycles.
- `done` never deasserts without reset.
- A write is visible in `core` on the edge that completes its state.

## Configuration
- `TOP_ASSERT_EN` defined: simulation-only assertions are compiled in.
  - State encoding is legal.
  - Write address lies in [OUT_BASE, OUT_BASE+2·NUM_MSG).
  - `done` never falls while `reset`=1.
  - No write occurs in FIN.
- Undefined: no assertion code; functional behaviour is identical.

## Structure
- Package `top_level_pkg` holds:
  - constants NUM_MSG, IN_BASE=0, OUT_BASE;
  - the state enum;
  - function `hamming_encode(logic [11:1]) → logic [15:0]`.
- Sub-module `dat_mem`: byte-wide RAM with array `core`, instantiated as `dm1`.
- FSM, counter and parity logic live in `top_level`.

## Test plan
- Walking one, message i = 1<<i:
  - d=0x001 → bytes 30/31 = 0x0F/0x00.
  - d=0x002 → 0x33/0x00.
  - d=0x400 (d11) → 0x17/0x81.
  - Messages 11–14 are all-zero (11-bit truncation) → codeword 0x0000.
- All-ones d=0x7FF → 0xFF/0xFF. Garbage in `core[2i+1][7:3]` must not affect the result.
- Latency: `done`=0 through cycle 60 after release, 1 at cycle 61 and after. Bytes 0–29 and 60–255 are unchanged.
- Reset mid-run (cycle 20): `done`=0 immediately. After re-release, the full correct output and `done` arrive at cycle 61.
- Random 11-bit messages, all 15 compared to the reference parity equations: score must be 15/15.

Source files
------------

// File: rtl/top_level_pkg.sv
// Shared constants, FSM state type and the SECDED encoder for the
// program-1 Hamming encoder.
package top_level_pkg;

    localparam int NUM_MSG   = 15;
    localparam int IN_BASE   = 0;
    localparam int OUT_BASE  = 30;
    localparam int MEM_DEPTH = 256;
    localparam int ADDR_W    = $clog2(MEM_DEPTH);
    localparam int CNT_W     = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4,
        FIN   = 3'd5
    } state_t;

    // Parity bits sit at codeword positions 8/4/2/1, overall parity at bit 0.
    function automatic logic [15:0] hamming_encode(input logic [11:1] d);
        logic p8, p4, p2, p1, p0;
        p8 = ^d[11:5];
        p4 = (^d[11:8]) ^ (^d[4:2]);
        p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
        p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
        p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
        return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
    endfunction

endpackage

// File: rtl/top_level_dat_mem.sv
// Single-port byte RAM: combinational read, synchronous write.
// Contents are not reset; the environment preloads them.
module dat_mem
    import top_level_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wr_data,
    output logic [7:0]        rd_data
);

    logic [7:0] core [0:MEM_DEPTH-1];

    assign rd_data = core[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            core[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/top_level.sv
// Program 1: reads 15 packed 11-bit messages, writes SECDED codewords, raises done.
// Define TOP_ASSERT_EN to compile in simulation-only protocol assertions.
module top_level
    import top_level_pkg::*;
(
    input  logic clk,
    input  logic reset,
    output logic done
);

    localparam logic [CNT_W-1:0]  LAST_MSG = CNT_W'(NUM_MSG - 1);
    localparam logic [ADDR_W-1:0] IN_A     = ADDR_W'(IN_BASE);
    localparam logic [ADDR_W-1:0] OUT_A    = ADDR_W'(OUT_BASE);
    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  i_q, i_d;
    logic              done_q, done_d;
    logic [7:0]        lo_q, lo_d;
    logic [2:0]        hi_q, hi_d;

    logic              wr_en;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wr_data;
    logic [7:0]        rd_data;
    logic [ADDR_W-1:0] idx2;
    logic [ADDR_W-1:0] in_addr;
    logic [ADDR_W-1:0] out_addr;
    logic [15:0]       codeword;

    assign idx2     = {{(ADDR_W-CNT_W-1){1'b0}}, i_q, 1'b0};
    assign in_addr  = IN_A + idx2;
    assign out_addr = OUT_A + idx2;
    // Only the low 3 bits of the high input byte carry message data.
    assign codeword = hamming_encode({hi_q, lo_q});
    assign done     = done_q;

    dat_mem dm1 (
        .clk     (clk),
        .wr_en   (wr_en),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        done_d  = done_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        wr_en   = 1'b0;
        addr    = in_addr;
        wr_data = codeword[7:0];
        case (state_q)
            IDLE: begin
                state_d = RD_LO;
            end
            RD_LO: begin
                addr    = in_addr;
                lo_d    = rd_data;
                state_d = RD_HI;
            end
            RD_HI: begin
                addr    = in_addr + ONE_A;
                hi_d    = rd_data[2:0];
                state_d = WR_LO;
            end
            WR_LO: begin
                addr    = out_addr;
                wr_en   = 1'b1;
                wr_data = codeword[7:0];
                state_d = WR_HI;
            end
            WR_HI: begin
                addr    = out_addr + ONE_A;
                wr_en   = 1'b1;
                wr_data = codeword[15:8];
                // Counter stops at the last message so it never exceeds NUM_MSG-1.
                if (i_q < LAST_MSG) begin
                    i_d     = i_q + CNT_W'(1);
                    state_d = RD_LO;
                end else begin
                    done_d  = 1'b1;
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = FIN;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        lo_q <= lo_d;
        hi_q <= hi_d;
    end

`ifdef TOP_ASSERT_EN
    localparam logic [ADDR_W:0] OUT_END = (ADDR_W+1)'(OUT_BASE + 2*NUM_MSG);

    a_state_legal: assert property (@(posedge clk) disable iff (!reset)
        state_q inside {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, FIN});

    a_wr_range: assert property (@(posedge clk) disable iff (!reset)
        wr_en |-> (addr >= OUT_A && {1'b0, addr} < OUT_END));

    a_done_sticky: assert property (@(posedge clk) disable iff (!reset)
        done_q |=> done_q);

    a_no_fin_write: assert property (@(posedge clk) disable iff (!reset)
        (state_q == FIN) |-> !wr_en);
`else
`endif

endmodule

// File: tb/tb_top_level.sv
// Self-checking bench for the program-1 SECDED encoder, with a
// position-based Hamming reference model.
module tb_top_level;
    import top_level_pkg::*;

    logic clk;
    logic reset;
    logic done;

    top_level dut (
        .clk   (clk),
        .reset (reset),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  shadow [0:255];
    logic [10:0] msg    [0:14];

    // Classic Hamming layout: data fills non-power-of-two positions 3..15,
    // parity at position p covers every position sharing bit p, bit 0 is overall parity.
    function automatic logic [15:0] ref_code(input logic [10:0] m);
        logic [15:0] cw;
        logic        x;
        int          k;
        cw = '0;
        k  = 0;
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos] = m[k];
                k++;
            end
        end
        for (int p = 1; p < 16; p = p * 2) begin
            x = 1'b0;
            for (int pos = 1; pos < 16; pos++)
                if ((pos & p) != 0 && pos != p) x ^= cw[pos];
            cw[p] = x;
        end
        cw[0] = ^cw[15:1];
        return cw;
    endfunction

    function automatic logic [15:0] dut_word(input int k);
        return {dut.dm1.core[OUT_BASE + 2*k + 1], dut.dm1.core[OUT_BASE + 2*k]};
    endfunction

    task automatic load_mem(input bit garbage);
        for (int a = 0; a < 256; a++) shadow[a] = 8'($urandom);
        for (int k = 0; k < 15; k++) begin
            shadow[2*k]   = msg[k][7:0];
            shadow[2*k+1] = {(garbage ? 5'($urandom) : 5'd0), msg[k][10:8]};
        end
        for (int a = 0; a < 256; a++) dut.dm1.core[a] = shadow[a];
    endtask

    task automatic enter_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_to_done(output int lat, output bit ok);
        reset = 1'b1;
        lat   = 0;
        ok    = 1'b0;
        while (lat < 200 && !ok) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        int bad;
        for (int k = 0; k < 15; k++) msg[k] = 11'($urandom);
        load_mem(1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL reset_done: got %b expected 0", done);
        end
        checks++;
        if (dut.i_q !== 4'd0) begin
            errors++; $display("FAIL reset_count: got %0d expected 0", dut.i_q);
        end
        checks++;
        if (dut.state_q !== IDLE) begin
            errors++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, IDLE);
        end
        bad = 0;
        for (int a = 0; a < 256; a++) if (dut.dm1.core[a] !== shadow[a]) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL reset_mem: got %0d changed bytes expected 0", bad);
        end
    endtask

    task automatic test_walking_one();
        int lat; bit ok;
        for (int k = 0; k < 15; k++) msg[k] = 11'(1 << k);
        enter_reset();
        load_mem(1'b0);
        run_to_done(lat, ok);
        checks++;
        if (!ok || lat != 61) begin
            errors++; $display("FAIL walk_latency: got %0d cycles (done=%b) expected 61", lat, done);
        end
        checks++;
        if (dut_word(0) !== 16'h000F) begin
            errors++; $display("FAIL walk_d1: got %h expected 000f", dut_word(0));
        end
        checks++;
        if (dut_word(1) !== 16'h0033) begin
            errors++; $display("FAIL walk_d2: got %h expected 0033", dut_word(1));
        end
        checks++;
        if (dut_word(10) !== 16'h8117) begin
            errors++; $display("FAIL walk_d11: got %h expected 8117", dut_word(10));
        end
        for (int k = 0; k < 15; k++) begin
            checks++;
            if (dut_word(k) !== ref_code(msg[k])) begin
                errors++; $display("FAIL walk_msg%0d: got %h expected %h", k, dut_word(k), ref_code(msg[k]));
            end
        end
        for (int k = 11; k < 15; k++) begin
            checks++;
            if (dut_word(k) !== 16'h0000) begin
                errors++; $display("FAIL walk_trunc%0d: got %h expected 0000", k, dut_word(k));
            end
        end
    endtask

    task automatic test_all_ones_garbage();
        int lat; bit ok;
        for (int k = 0; k < 15; k++) msg[k] = 11'h7FF;
        enter_reset();
        load_mem(1'b1);
        run_to_done(lat, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL ones_timeout: got done=%b expected 1", done);
        end
        for (int k = 0; k < 15; k++) begin
            checks++;
            if (dut_word(k) !== 16'hFFFF) begin
                errors++; $display("FAIL ones_msg%0d: got %h expected ffff", k, dut_word(k));
            end
        end
    endtask

    task automatic test_latency();
        int bad;
        logic exp_done;
        for (int k = 0; k < 15; k++) msg[k] = 11'($urandom);
        enter_reset();
        load_mem(1'b1);
        reset = 1'b1;
        for (int cyc = 1; cyc <= 71; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            exp_done = (cyc >= 61);
            checks++;
            if (done !== exp_done) begin
                errors++; $display("FAIL lat_cycle%0d: got done=%b expected %b", cyc, done, exp_done);
            end
        end
        bad = 0;
        for (int a = 0; a < 256; a++)
            if ((a < OUT_BASE || a >= OUT_BASE + 2*NUM_MSG) && dut.dm1.core[a] !== shadow[a]) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL lat_untouched: got %0d changed bytes expected 0", bad);
        end
        for (int k = 0; k < 15; k++) begin
            checks++;
            if (dut_word(k) !== ref_code(msg[k])) begin
                errors++; $display("FAIL lat_msg%0d: got %h expected %h", k, dut_word(k), ref_code(msg[k]));
            end
        end
    endtask

    task automatic test_reset_midrun();
        int lat; bit ok;
        logic [15:0] c4;
        for (int k = 0; k < 15; k++) msg[k] = 11'($urandom);
        enter_reset();
        load_mem(1'b1);
        reset = 1'b1;
        repeat (20) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL mid_done: got %b expected 0", done);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (dut_word(k) !== ref_code(msg[k])) begin
                errors++; $display("FAIL mid_partial%0d: got %h expected %h", k, dut_word(k), ref_code(msg[k]));
            end
        end
        c4 = ref_code(msg[4]);
        checks++;
        if (dut.dm1.core[OUT_BASE+8] !== c4[7:0] || dut.dm1.core[OUT_BASE+9] !== shadow[OUT_BASE+9]) begin
            errors++; $display("FAIL mid_msg4: got %h%h expected %h%h", dut.dm1.core[OUT_BASE+9],
                dut.dm1.core[OUT_BASE+8], shadow[OUT_BASE+9], c4[7:0]);
        end
        repeat (3) @(negedge clk);
        run_to_done(lat, ok);
        checks++;
        if (!ok || lat != 61) begin
            errors++; $display("FAIL mid_latency: got %0d cycles (done=%b) expected 61", lat, done);
        end
        for (int k = 0; k < 15; k++) begin
            checks++;
            if (dut_word(k) !== ref_code(msg[k])) begin
                errors++; $display("FAIL mid_msg%0d: got %h expected %h", k, dut_word(k), ref_code(msg[k]));
            end
        end
    endtask

    task automatic test_random();
        int lat; bit ok; int score;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 15; k++) msg[k] = 11'($urandom);
            enter_reset();
            load_mem(1'b1);
            run_to_done(lat, ok);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL rand%0d_timeout: got done=%b expected 1", r, done);
            end
            score = 0;
            for (int k = 0; k < 15; k++) begin
                checks++;
                if (dut_word(k) !== ref_code(msg[k])) begin
                    errors++; $display("FAIL rand%0d_msg%0d: got %h expected %h", r, k, dut_word(k), ref_code(msg[k]));
                end else begin
                    score++;
                end
            end
            checks++;
            if (score != 15) begin
                errors++; $display("FAIL rand%0d_score: got %0d/15 expected 15/15", r, score);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        #2 reset = 1'b0;
        test_reset();
        test_walking_one();
        test_all_ones_garbage();
        test_latency();
        test_reset_midrun();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
